// File: rtl/dip_switch_reader.sv
// rtl/dip_switch_reader.sv - synchronised, whole-bank debounced DIP switch reader with valid/ready update port
module dip_switch_reader #(
  parameter int WIDTH           = 8,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] sw_in,
  output logic [WIDTH-1:0] sw_stable,
  output logic [WIDTH-1:0] sw_data,
  output logic             sw_valid,
  input  logic             sw_ready,
  output logic             sw_overrun,
  output logic [7:0]       event_count
);

  localparam logic [0:0] ST_IDLE    = 1'b0;
  localparam logic [0:0] ST_PENDING = 1'b1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [WIDTH-1:0] s1, s2, cand;
  logic [CNT_W-1:0] cnt;
  logic [0:0]       state;
  logic             upd;

  // A new value is accepted only when the candidate has held for the full window
  assign upd = (s2 == cand) && (cand != sw_stable) && (cnt == CNT_MAX);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= sw_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cand        <= '0;
      cnt         <= '0;
      sw_stable   <= '0;
      event_count <= '0;
    end else if (s2 != cand) begin
      cand <= s2;
      cnt  <= '0;
    end else if (cand == sw_stable) begin
      cnt <= '0;
    end else if (cnt == CNT_MAX) begin
      sw_stable   <= cand;
      cnt         <= '0;
      event_count <= event_count + 8'd1;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  // Overrun is sticky until the consumer takes the overwritten value
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      sw_data    <= '0;
      sw_overrun <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (upd) begin
            sw_data    <= cand;
            state      <= ST_PENDING;
            sw_overrun <= 1'b0;
          end
        end
        ST_PENDING: begin
          if (upd) begin
            sw_data <= cand;
            if (sw_ready) sw_overrun <= 1'b0;
            else          sw_overrun <= 1'b1;
          end else if (sw_ready) begin
            state      <= ST_IDLE;
            sw_overrun <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign sw_valid = (state == ST_PENDING);

endmodule

// File: tb/tb_dip_switch_reader.sv
// tb/tb_dip_switch_reader.sv - scoreboard bench for dip_switch_reader with DEBOUNCE_CYCLES=4
module tb_dip_switch_reader;

  typedef struct packed {
    logic [7:0] data;
    logic       ov;
    logic [7:0] ev;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] sw_in;
  logic [7:0] sw_stable;
  logic [7:0] sw_data;
  logic       sw_valid;
  logic       sw_ready;
  logic       sw_overrun;
  logic [7:0] event_count;

  int vectors = 0;
  int miscompares = 0;
  exp_t q[$];
  logic [7:0] ev_exp = 8'd0;

  dip_switch_reader #(.WIDTH(8), .DEBOUNCE_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .sw_in(sw_in),
    .sw_stable(sw_stable),
    .sw_data(sw_data),
    .sw_valid(sw_valid),
    .sw_ready(sw_ready),
    .sw_overrun(sw_overrun),
    .event_count(event_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] d, input logic ov, input logic [7:0] ev);
    exp_t e;
    e.data = d;
    e.ov   = ov;
    e.ev   = ev;
    q.push_back(e);
  endtask

  task automatic apply_and_accept(input logic [7:0] v);
    sw_in  = v;
    ev_exp = ev_exp + 8'd1;
    push_exp(v, 1'b0, ev_exp);
    tick(6);
    check("early_valid", sw_valid, 0);
    tick(1);
    check("upd_valid", sw_valid, 1);
    check("upd_stable", sw_stable, v);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("accept_clears", sw_valid, 0);
  endtask

  // Monitor: every handshake must match the oldest expected update
  always @(negedge clk) begin
    if (rst_n === 1'b1 && sw_valid === 1'b1 && sw_ready === 1'b1) begin
      vectors++;
      if (q.size() == 0) begin
        miscompares++;
        $display("FAIL unexpected_update: got data %0h with no expected entry", sw_data);
      end else begin
        exp_t e;
        e = q.pop_front();
        check("mon_data", sw_data, e.data);
        check("mon_overrun", sw_overrun, e.ov);
        check("mon_event_count", event_count, e.ev);
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL timeout: simulation did not finish, vectors %0d", vectors);
    $fatal(1);
  end

  initial begin
    rst_n    = 1'b0;
    sw_in    = 8'hA5;
    sw_ready = 1'b0;
    tick(3);
    check("rst_stable", sw_stable, 0);
    check("rst_data", sw_data, 0);
    check("rst_valid", sw_valid, 0);
    check("rst_overrun", sw_overrun, 0);
    check("rst_event_count", event_count, 0);

    // Nonzero switches at release: one update at edge 7
    rst_n = 1'b1;
    tick(6);
    check("t1_valid_e6", sw_valid, 0);
    check("t1_stable_e6", sw_stable, 0);
    tick(1);
    check("t1_valid_e7", sw_valid, 1);
    check("t1_data", sw_data, 8'hA5);
    check("t1_stable", sw_stable, 8'hA5);
    check("t1_event_count", event_count, 1);
    ev_exp = 8'd1;
    push_exp(8'hA5, 1'b0, 8'd1);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("t1_valid_cleared", sw_valid, 0);

    // Bouncing bit 2 yields a single update 7 edges after the last toggle
    apply_and_accept(8'h00);
    sw_in = 8'h3C;
    for (int i = 0; i < 5; i++) begin
      tick(2);
      check("t2_bounce_valid", sw_valid, 0);
      sw_in = sw_in ^ 8'h04;
    end
    tick(2);
    check("t2_bounce_valid", sw_valid, 0);
    sw_in = 8'h3C;
    tick(6);
    check("t2_valid_e6", sw_valid, 0);
    check("t2_event_count_e6", event_count, 2);
    tick(1);
    check("t2_valid_e7", sw_valid, 1);
    check("t2_data", sw_data, 8'h3C);
    ev_exp = 8'd3;
    push_exp(8'h3C, 1'b0, 8'd3);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("t2_valid_cleared", sw_valid, 0);

    // Overwrite while not ready sets sticky overrun
    sw_in = 8'h11;
    tick(7);
    check("t3_valid_11", sw_valid, 1);
    check("t3_data_11", sw_data, 8'h11);
    sw_in = 8'h22;
    tick(7);
    check("t3_data_22", sw_data, 8'h22);
    check("t3_overrun", sw_overrun, 1);
    check("t3_event_count", event_count, 5);
    ev_exp = 8'd5;
    push_exp(8'h22, 1'b1, 8'd5);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("t3_valid_cleared", sw_valid, 0);
    check("t3_overrun_cleared", sw_overrun, 0);

    // Update lands on the same edge the previous one is accepted
    sw_in = 8'h44;
    tick(7);
    check("t4_valid_44", sw_valid, 1);
    sw_in = 8'h55;
    tick(6);
    push_exp(8'h44, 1'b0, 8'd6);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("t4_valid_held", sw_valid, 1);
    check("t4_data_55", sw_data, 8'h55);
    check("t4_overrun", sw_overrun, 0);
    check("t4_event_count", event_count, 7);
    ev_exp = 8'd7;
    push_exp(8'h55, 1'b0, 8'd7);
    sw_ready = 1'b1;
    tick(1);
    sw_ready = 1'b0;
    check("t4_valid_cleared", sw_valid, 0);

    // Short pulse shorter than the window is rejected
    sw_in = 8'hFF;
    tick(3);
    sw_in = 8'h55;
    tick(10);
    check("t5_valid", sw_valid, 0);
    check("t5_stable", sw_stable, 8'h55);
    check("t5_event_count", event_count, 7);

    // Drive event_count round to wrap at 256
    for (int i = 0; i < 249; i++) begin
      apply_and_accept((i % 2 == 0) ? 8'hAA : 8'h55);
    end
    check("t6_event_wrap", event_count, 0);

    // Reset mid-debounce discards the pending candidate
    sw_in = 8'h0F;
    tick(4);
    rst_n = 1'b0;
    sw_in = 8'h00;
    tick(1);
    check("t6_rst_stable", sw_stable, 0);
    check("t6_rst_data", sw_data, 0);
    check("t6_rst_valid", sw_valid, 0);
    check("t6_rst_overrun", sw_overrun, 0);
    check("t6_rst_event_count", event_count, 0);
    tick(2);
    rst_n = 1'b1;
    tick(10);
    check("t6_post_valid", sw_valid, 0);
    check("t6_post_event_count", event_count, 0);
    check("t6_post_stable", sw_stable, 0);

    check("queue_drained", q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
